// File: rtl/div_pkg.sv
// Shared types and defaults for the div_sched divider scheduler.
package div_pkg;

  localparam int DIV_DATA_W  = 64;
  localparam int DIV_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } div_state_e;

  // Operand register: owner id plus the latched dividend/divisor.
  typedef struct packed {
    logic                         id;
    logic signed [DIV_DATA_W-1:0] a;
    logic signed [DIV_DATA_W-1:0] b;
  } div_op_t;

endpackage

// File: rtl/div_sched_if.sv
// Request/response bundle for div_sched: two valid/ready requesters and
// one valid/ready response channel. master = requesters/consumer side,
// slave = scheduler side.
interface div_sched_if
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);

  logic                     req0_valid;
  logic                     req0_ready;
  logic signed [DATA_W-1:0] req0_a;
  logic signed [DATA_W-1:0] req0_b;

  logic                     req1_valid;
  logic                     req1_ready;
  logic signed [DATA_W-1:0] req1_a;
  logic signed [DATA_W-1:0] req1_b;

  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_id;
  logic signed [DATA_W-1:0] resp_quotient;
  logic signed [DATA_W-1:0] resp_remainder;
  logic                     resp_overflow;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_overflow,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output resp_valid, resp_id, resp_quotient, resp_remainder, resp_overflow,
    input  resp_ready
  );

endinterface

// File: rtl/div_rr_arb.sv
// Two-way round-robin arbiter. Grant is combinational from valid and the
// pointer; the pointer only moves on advance, and then to the loser.
module div_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       ptr_r;
  logic [1:0] grant_s;

  // Pick the lone valid requester, or the pointed-to one on contention.
  always_comb begin
    grant_s = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign grant = grant_s;

  // Pointer hands priority to the requester that was not just served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (advance) begin
      ptr_r <= grant_s[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/divider.sv
// Combinational signed divider. Truncates toward zero, remainder follows the
// dividend's sign. Divide-by-zero returns all-ones quotient and the dividend
// as remainder; MIN / -1 returns MIN with zero remainder. Both raise overflow.
module divider #(
  parameter int DATA_W = 64
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] quotient,
  output logic signed [DATA_W-1:0] remainder,
  output logic                     overflow
);

  localparam logic signed [DATA_W-1:0] MIN_V  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] NEG1_V = {DATA_W{1'b1}};
  localparam logic signed [DATA_W-1:0] ZERO_V = {DATA_W{1'b0}};

  // Divide with the two corner cases resolved to defined values.
  always_comb begin
    quotient  = ZERO_V;
    remainder = ZERO_V;
    overflow  = 1'b0;
    if (b == ZERO_V) begin
      quotient  = NEG1_V;
      remainder = a;
      overflow  = 1'b1;
    end else if ((a == MIN_V) && (b == NEG1_V)) begin
      quotient  = MIN_V;
      remainder = ZERO_V;
      overflow  = 1'b1;
    end else begin
      quotient  = a / b;
      remainder = a % b;
      overflow  = 1'b0;
    end
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: shares one combinational signed divider between two requesters.
// An accepted operation is held on the divider for LATENCY cycles (multicycle
// path), then the registered result is returned with its owner id.
// Optional feature macro: DIV_SCHED_ZERO_BYPASS_EN -- divide-by-zero is
// answered straight from the accept, skipping the divider window.
module div_sched
  import div_pkg::*;
#(
  parameter int DATA_W  = DIV_DATA_W,
  parameter int LATENCY = DIV_LATENCY
) (
  input  logic            clk,
  input  logic            rst_n,
  div_sched_if.slave      bus,
  output logic            busy
);

  localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  div_state_e  state_r;
  div_state_e  state_s;
  logic [CNT_W-1:0] cnt_r;
  div_op_t     op_r;
  div_op_t     sel_op_s;
  logic [1:0]  grant_s;
  logic        accept_s;
  logic        capture_s;
  logic        handshake_s;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
  logic        bypass_s;
`endif

  logic signed [DIV_DATA_W-1:0] div_q_s;
  logic signed [DIV_DATA_W-1:0] div_r_s;
  logic                         div_ovf_s;

  logic                         resp_valid_r;
  logic                         resp_id_r;
  logic signed [DIV_DATA_W-1:0] resp_q_r;
  logic signed [DIV_DATA_W-1:0] resp_r_r;
  logic                         resp_ovf_r;
  logic                         busy_r;

  div_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .enable  (state_r == ST_IDLE),
    .advance (accept_s),
    .grant   (grant_s)
  );

  // The divider only ever sees the operand register, so it is stable for the
  // whole window regardless of what the requesters do.
  divider #(.DATA_W(DIV_DATA_W)) u_div (
    .a         (op_r.a),
    .b         (op_r.b),
    .quotient  (div_q_s),
    .remainder (div_r_s),
    .overflow  (div_ovf_s)
  );

  // Mux the granted requester's operands toward the operand register.
  always_comb begin
    sel_op_s = {$bits(div_op_t){1'b0}};
    if (grant_s[1]) begin
      sel_op_s.id = 1'b1;
      sel_op_s.a  = bus.req1_a;
      sel_op_s.b  = bus.req1_b;
    end else begin
      sel_op_s.id = 1'b0;
      sel_op_s.a  = bus.req0_a;
      sel_op_s.b  = bus.req0_b;
    end
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    handshake_s = 1'b0;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    bypass_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        accept_s = |grant_s;
        if (accept_s) begin
`ifdef DIV_SCHED_ZERO_BYPASS_EN
          if (sel_op_s.b == {DIV_DATA_W{1'b0}}) begin
            bypass_s = 1'b1;
            state_s  = ST_RESP;
          end else begin
            state_s  = ST_EXEC;
          end
`else
          state_s = ST_EXEC;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == CNT_ZERO) begin
          capture_s = 1'b1;
          state_s   = ST_RESP;
        end else begin
          state_s   = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (resp_valid_r && bus.resp_ready) begin
          handshake_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, window counter and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (accept_s) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == ST_EXEC) && (cnt_r != CNT_ZERO)) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Operand register, loaded only on an accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r <= {$bits(div_op_t){1'b0}};
    end else if (accept_s) begin
      op_r <= sel_op_s;
    end else begin
      op_r <= op_r;
    end
  end

  // Response registers: loaded at the end of the window, held until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_q_r     <= {DIV_DATA_W{1'b0}};
      resp_r_r     <= {DIV_DATA_W{1'b0}};
      resp_ovf_r   <= 1'b0;
    end else if (capture_s) begin
      resp_valid_r <= 1'b1;
      resp_id_r    <= op_r.id;
      resp_q_r     <= div_q_s;
      resp_r_r     <= div_r_s;
      resp_ovf_r   <= div_ovf_s;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    end else if (bypass_s) begin
      resp_valid_r <= 1'b1;
      resp_id_r    <= sel_op_s.id;
      resp_q_r     <= {DIV_DATA_W{1'b1}};
      resp_r_r     <= sel_op_s.a;
      resp_ovf_r   <= 1'b1;
`endif
    end else if (handshake_s) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  assign bus.req0_ready     = grant_s[0];
  assign bus.req1_ready     = grant_s[1];
  assign bus.resp_valid     = resp_valid_r;
  assign bus.resp_id        = resp_id_r;
  assign bus.resp_quotient  = resp_q_r;
  assign bus.resp_remainder = resp_r_r;
  assign bus.resp_overflow  = resp_ovf_r;
  assign busy               = busy_r;

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Sequencer and arbiter that shares one combinational 64-bit signed divider (`divider`) between two requesters.
- Each requester uses a valid/ready handshake. The scheduler accepts one operation at a time and holds the operands on the divider for LATENCY cycles, so the long combinational path is treated as multicycle.
- It then registers quotient, remainder and overflow, and returns them with the requester ID over a valid/ready response channel.

Parameters:
- DATA_W, 64, operand and result width.
- LATENCY, 2, cycles the operands are held on the divider before results are captured. Legal range ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DATA_W  requester 0 signed dividend.
- req0_b  in  DATA_W  requester 0 signed divisor.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  index of the requester that owns the result.
- resp_quotient  out  DATA_W  signed quotient.
- resp_remainder  out  DATA_W  signed remainder.
- resp_overflow  out  1  divider overflow flag.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n low at a clock edge, including mid-operation):
  - State returns to IDLE and any in-flight operation is discarded.
  - All outputs go to 0, the operand registers clear to 0, and the round-robin pointer is set to 0 (requester 0 has priority).
- State machine:
  - IDLE → EXEC on an accept.
  - EXEC → RESP when the counter reaches 0.
  - RESP → IDLE on resp_valid && resp_ready.
- IDLE, arbitration:
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from valid and pointer; at most one ready is high.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester the pointer names is granted.
  - On an accept, the pointer moves to the other requester. The pointer does not change in idle cycles.
- IDLE, accept:
  - On reqN_valid && reqN_ready, latch a, b and id into the operand registers.
  - Load the counter with LATENCY-1.
- EXEC:
  - Only the operand registers drive the divider inputs; operands are stable for the whole window.
  - Counter decrements each cycle.
  - At counter==0, capture quotient, r and overflow into the response registers, assert resp_valid on the next cycle, and enter RESP.
- RESP:
  - resp_* outputs are held stable until resp_ready.
  - On handshake, resp_valid drops next cycle and state returns to IDLE.
  - No new accept in the handshake cycle; the earliest accept is in the following cycle.
- Throughput: one operation per LATENCY+2 cycles with no backpressure. Latency from accept edge to resp_valid high is LATENCY cycles.
- Arithmetic:
  - Signed two's complement division, truncating toward zero; the remainder takes the sign of the dividend.
  - The divider's outputs are passed through unmodified.
- Boundaries:
  - A requester whose valid is held while it is not granted loses nothing; its operands must stay stable until ready.
  - Valid dropped before ready: no operation takes place.
  - Inputs are not sampled in EXEC or RESP.

Optional Feature:
- Macro: DIV_SCHED_ZERO_BYPASS_EN.
- Defined:
  - On accept with b==0, skip EXEC and go directly to RESP.
  - Response registers load quotient={DATA_W{1'b1}}, remainder=a, overflow=1.
  - resp_valid is high 1 cycle after the accept edge.
- Undefined:
  - b==0 takes the normal EXEC path.
  - Results are whatever the divider produces.

Decomposition:
- Shared package div_pkg holds:
  - DIV_DATA_W=64 and the default DIV_LATENCY.
  - The state enum (ST_IDLE, ST_EXEC, ST_RESP).
  - A struct {id, a, b} for the operand register.
- Natural sub-module: div_rr_arb, a 2-way round-robin arbiter.
  - Inputs: valid[1:0], enable, advance.
  - Outputs: grant one-hot.
  - It owns the pointer.
- `divider` is instantiated unchanged.

Test Plan:
- Reset with both req valid, req0 a=78 b=97, req1 a=-24878735 b=-879357:
  - req0 granted first: resp_id=0, q=0, r=78, overflow=0.
  - req1 granted next: resp_id=1, q=28, r=-256739.
- LATENCY=2, single req0 a=20 b=-5:
  - req0_ready high in cycle 0 (accept edge), resp_valid high 2 cycles later.
  - q=-4, r=0, busy high 3 cycles (resp_ready tied high).
- Backpressure, a=-45 b=65437:
  - resp_ready held low 5 cycles; resp_valid stays high and q=0, r=-45 stay stable.
  - Both readys stay low; drop to IDLE one cycle after resp_ready rises.
- Fairness, both requesters continuously valid with a=-20 b=5:
  - resp_id sequence is 0,1,0,1.
  - Every result is q=-4, r=0.
- Reset mid-EXEC: assert rst_n=0 one cycle after accepting a=2504532 b=945327.
  - No response is emitted, all outputs are 0, busy=0.
  - The next req1 request returns q=2, r=613878.
- With DIV_SCHED_ZERO_BYPASS_EN defined, req0 a=20 b=0:
  - resp_valid high 1 cycle after accept.
  - q=64'hFFFF_FFFF_FFFF_FFFF, r=20, overflow=1.
